ray_step_unit: RTL and testbench

//  Ray-march position stage: computes p = origin + dir * t per ray in fixed point (fp, Q(32-FRAC_BITS).FRAC_BITS).

---
 rtl/ray_step_unit_pkg.sv | 69 ++++++
 rtl/ray_step_lane.sv | 57 +++++
 rtl/ray_step_unit.sv | 128 ++++++++++++
 tb/tb_ray_step_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ray_step_unit_pkg.sv
// Shared fixed-point types and arithmetic helpers for the ray step unit.
// The saturating helpers are used only when RAY_STEP_SATURATE_EN is defined.
package ray_step_unit_pkg;

    localparam int FRAC_BITS = 16;

    typedef logic signed [31:0] fp_t;

    typedef struct packed {
        fp_t x;
        fp_t y;
        fp_t z;
    } vec3_t;

    localparam fp_t FP_MAX = 32'sh7FFF_FFFF;
    localparam fp_t FP_MIN = 32'sh8000_0000;

    localparam logic signed [63:0] FP_MAX_W = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [63:0] FP_MIN_W = 64'shFFFF_FFFF_8000_0000;

    // Full-width product, rescaled back to FRAC_BITS fractional bits before any narrowing.
    function automatic logic signed [63:0] fp_mul_wide(input fp_t a, input fp_t b);
        logic signed [63:0] a_w;
        logic signed [63:0] b_w;
        logic signed [63:0] p_w;
        a_w = {{32{a[31]}}, a};
        b_w = {{32{b[31]}}, b};
        p_w = a_w * b_w;
        return p_w >>> FRAC_BITS;
    endfunction

    function automatic fp_t fp_mul(input fp_t a, input fp_t b);
        logic signed [63:0] w;
        w = fp_mul_wide(a, b);
        return w[31:0];
    endfunction

    function automatic fp_t fp_mul_sat(input fp_t a, input fp_t b);
        logic signed [63:0] w;
        fp_t r;
        w = fp_mul_wide(a, b);
        if (w > FP_MAX_W) begin
            r = FP_MAX;
        end else if (w < FP_MIN_W) begin
            r = FP_MIN;
        end else begin
            r = w[31:0];
        end
        return r;
    endfunction

    function automatic fp_t fp_add(input fp_t a, input fp_t b);
        return a + b;
    endfunction

    // Overflow only possible when both operands share a sign and the sum flips it.
    function automatic fp_t fp_add_sat(input fp_t a, input fp_t b);
        fp_t s;
        fp_t r;
        s = a + b;
        if ((a[31] == b[31]) && (s[31] != a[31])) begin
            r = a[31] ? FP_MIN : FP_MAX;
        end else begin
            r = s;
        end
        return r;
    endfunction

endpackage

// File: rtl/ray_step_lane.sv
// One coordinate lane of the ray step: dir*t in S1, origin+product in S2.
// RAY_STEP_SATURATE_EN selects clamping arithmetic instead of wrapping.
module ray_step_lane
    import ray_step_unit_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic s1_load,
    input  logic s2_load,
    input  fp_t  origin,
    input  fp_t  dir,
    input  fp_t  t,
    output fp_t  pos
);

    fp_t prod_s;
    fp_t sum_s;
    fp_t prod_r;
    fp_t origin_r;
    fp_t pos_r;

    // Narrowed product for S1 and lane sum for S2.
    always_comb begin
        prod_s = '0;
        sum_s  = '0;
`ifdef RAY_STEP_SATURATE_EN
        prod_s = fp_mul_sat(dir, t);
        sum_s  = fp_add_sat(origin_r, prod_r);
`else
        prod_s = fp_mul(dir, t);
        sum_s  = fp_add(origin_r, prod_r);
`endif
    end

    // S1 data registers: product and origin, loaded with the incoming ray.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r   <= 32'sh0000_0000;
            origin_r <= 32'sh0000_0000;
        end else if (s1_load) begin
            prod_r   <= prod_s;
            origin_r <= origin;
        end
    end

    // S2 output register: position, held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_r <= 32'sh0000_0000;
        end else if (s2_load) begin
            pos_r <= sum_s;
        end
    end

    assign pos = pos_r;

endmodule

// File: rtl/ray_step_unit.sv
// Ray-march position stage: out_pos = origin + dir*t, 2-stage valid/ready pipeline.
// Optional feature macro: RAY_STEP_SATURATE_EN (saturating multiply/add in the lanes).
module ray_step_unit
    import ray_step_unit_pkg::*;
#(
    parameter int  ID_W  = 8,
    parameter fp_t T_MAX = 32'sh0064_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  vec3_t           in_origin,
    input  vec3_t           in_dir,
    input  fp_t             in_t,
    input  logic [ID_W-1:0] in_id,
    output logic            out_valid,
    input  logic            out_ready,
    output vec3_t           out_pos,
    output fp_t             out_t,
    output logic [ID_W-1:0] out_id,
    output logic            out_escaped
);

    logic            s1_valid_r;
    logic            s2_valid_r;
    logic            s1_advance_s;
    logic            in_ready_s;
    logic            s1_load_s;
    logic            s2_load_s;
    logic            escape_s;
    fp_t             s1_t_r;
    fp_t             s2_t_r;
    logic [ID_W-1:0] s1_id_r;
    logic [ID_W-1:0] s2_id_r;
    logic            s1_esc_r;
    logic            s2_esc_r;

    // Handshake: a stage loads when empty or when its current contents move on.
    always_comb begin
        s1_advance_s = (!s2_valid_r) || out_ready;
        in_ready_s   = (!s1_valid_r) || s1_advance_s;
        s1_load_s    = in_valid && in_ready_s;
        s2_load_s    = s1_valid_r && s1_advance_s;
        escape_s     = (in_t > T_MAX);
    end

    // Stage occupancy flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
        end else begin
            if (in_ready_s) begin
                s1_valid_r <= in_valid;
            end
            if (s1_advance_s) begin
                s2_valid_r <= s1_valid_r;
            end
        end
    end

    // S1 side-band: t, id and escape flag travel with the ray.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_t_r   <= 32'sh0000_0000;
            s1_id_r  <= {ID_W{1'b0}};
            s1_esc_r <= 1'b0;
        end else if (s1_load_s) begin
            s1_t_r   <= in_t;
            s1_id_r  <= in_id;
            s1_esc_r <= escape_s;
        end
    end

    // S2 side-band output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_t_r   <= 32'sh0000_0000;
            s2_id_r  <= {ID_W{1'b0}};
            s2_esc_r <= 1'b0;
        end else if (s2_load_s) begin
            s2_t_r   <= s1_t_r;
            s2_id_r  <= s1_id_r;
            s2_esc_r <= s1_esc_r;
        end
    end

    ray_step_lane u_lane_x (
        .clk     (clk),
        .rst_n   (rst_n),
        .s1_load (s1_load_s),
        .s2_load (s2_load_s),
        .origin  (in_origin.x),
        .dir     (in_dir.x),
        .t       (in_t),
        .pos     (out_pos.x)
    );

    ray_step_lane u_lane_y (
        .clk     (clk),
        .rst_n   (rst_n),
        .s1_load (s1_load_s),
        .s2_load (s2_load_s),
        .origin  (in_origin.y),
        .dir     (in_dir.y),
        .t       (in_t),
        .pos     (out_pos.y)
    );

    ray_step_lane u_lane_z (
        .clk     (clk),
        .rst_n   (rst_n),
        .s1_load (s1_load_s),
        .s2_load (s2_load_s),
        .origin  (in_origin.z),
        .dir     (in_dir.z),
        .t       (in_t),
        .pos     (out_pos.z)
    );

    assign in_ready    = in_ready_s;
    assign out_valid   = s2_valid_r;
    assign out_t       = s2_t_r;
    assign out_id      = s2_id_r;
    assign out_escaped = s2_esc_r;

endmodule

// File: tb/tb_ray_step_unit.sv
// Directed testbench for ray_step_unit (Q16.16), expected values hand-computed.
module tb_ray_step_unit;
    import ray_step_unit_pkg::*;

    localparam int ID_W = 8;
    localparam int NV   = 14;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    vec3_t           in_origin;
    vec3_t           in_dir;
    fp_t             in_t;
    logic [ID_W-1:0] in_id;
    logic            out_valid;
    logic            out_ready;
    vec3_t           out_pos;
    fp_t             out_t;
    logic [ID_W-1:0] out_id;
    logic            out_escaped;

    int n_checks = 0;
    int n_errors = 0;

    vec3_t           v_org [NV];
    vec3_t           v_dir [NV];
    vec3_t           v_pos [NV];
    fp_t             v_t   [NV];
    logic [ID_W-1:0] v_id  [NV];
    logic            v_esc [NV];

    always #5 clk = ~clk;

    ray_step_unit #(.ID_W(ID_W), .T_MAX(32'sh0064_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_origin   (in_origin),
        .in_dir      (in_dir),
        .in_t        (in_t),
        .in_id       (in_id),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pos     (out_pos),
        .out_t       (out_t),
        .out_id      (out_id),
        .out_escaped (out_escaped)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_vec(input int i,
                           input logic [31:0] ox, input logic [31:0] oy, input logic [31:0] oz,
                           input logic [31:0] dx, input logic [31:0] dy, input logic [31:0] dz,
                           input logic [31:0] t,  input logic [7:0] id,
                           input logic [31:0] px, input logic [31:0] py, input logic [31:0] pz,
                           input logic esc);
        v_org[i] = {ox, oy, oz};
        v_dir[i] = {dx, dy, dz};
        v_t[i]   = t;
        v_id[i]  = id;
        v_pos[i] = {px, py, pz};
        v_esc[i] = esc;
    endtask

    task automatic drive(input int i);
        in_origin = v_org[i];
        in_dir    = v_dir[i];
        in_t      = v_t[i];
        in_id     = v_id[i];
    endtask

    task automatic check_out(input int i);
        chk($sformatf("pos[%0d]", i), out_pos, v_pos[i]);
        chk($sformatf("t[%0d]", i), 96'(out_t), 96'(v_t[i]));
        chk($sformatf("id[%0d]", i), 96'(out_id), 96'(v_id[i]));
        chk($sformatf("esc[%0d]", i), 96'(out_escaped), 96'(v_esc[i]));
    endtask

    // Stream n rays starting at table index base; rnd=1 randomises out_ready.
    task automatic run_seq(input int base, input int n, input bit rnd);
        int    sent;
        int    got;
        int    cyc;
        int    inflight;
        bit    held;
        vec3_t held_pos;
        sent = 0; got = 0; cyc = 0; held = 1'b0; held_pos = '0;
        while ((sent < n || got < n) && cyc < 200) begin
            @(negedge clk);
            if (held) begin
                chk("hold_valid", 96'(out_valid), 96'(1'b1));
                chk("hold_pos", out_pos, held_pos);
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = (sent < n);
            if (sent < n) drive(base + sent);
            #1;
            inflight = sent - got;
            chk("in_ready", 96'(in_ready), 96'(!(inflight == 2 && !out_ready)));
            if (out_valid && out_ready) begin
                if (got < n) check_out(base + got);
                else chk("extra_out", 96'(1'b1), 96'(1'b0));
                got++;
            end
            held     = out_valid && !out_ready;
            held_pos = out_pos;
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        chk("seq_done", 96'(got), 96'(n));
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("drain_empty", 96'(out_valid), 96'(1'b0));
    endtask

    initial begin
        // Test 1 ray
        set_vec(0, 32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000,
                   32'h0000_8000, 32'h0000_0000, 32'hFFFF_C000,
                   32'h0004_0000, 8'hA5,
                   32'h0003_0000, 32'h0002_0000, 32'hFFFE_0000, 1'b0);
        // Rays 0..7: origin=(i,1,0) dir=(1,-0.5,2) t=i+1 -> pos=(2i+1, 1-0.5(i+1), 2(i+1))
        for (int i = 0; i < 8; i++) begin
            set_vec(1 + i, 32'(i * 65536), 32'h0001_0000, 32'h0000_0000,
                           32'h0001_0000, 32'hFFFF_8000, 32'h0002_0000,
                           32'((i + 1) * 65536), 8'(i),
                           32'((2 * i + 1) * 65536), 32'(65536 - (i + 1) * 32768),
                           32'(2 * (i + 1) * 65536), 1'b0);
        end
        // Escape boundary and negative t
        set_vec(9,  32'h0001_0000, 32'h0000_0000, 32'h0000_0000,
                    32'h0000_0000, 32'h0000_0000, 32'h0000_4000,
                    32'h0064_0000, 8'h10,
                    32'h0001_0000, 32'h0000_0000, 32'h0019_0000, 1'b0);
        set_vec(10, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
                    32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
                    32'h0064_0001, 8'h11,
                    32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 1'b1);
        set_vec(11, 32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000,
                    32'h0000_8000, 32'h0000_0000, 32'hFFFF_C000,
                    32'hFFFF_0000, 8'h12,
                    32'h0000_8000, 32'h0002_0000, 32'hFFFF_4000, 1'b0);
        // Overflow case
`ifdef RAY_STEP_SATURATE_EN
        set_vec(12, 32'h7FFF_0000, 32'h0000_0000, 32'h0000_0000,
                    32'h0001_0000, 32'h0000_0000, 32'h0000_0000,
                    32'h0002_0000, 8'h20,
                    32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0);
`else
        set_vec(12, 32'h7FFF_0000, 32'h0000_0000, 32'h0000_0000,
                    32'h0001_0000, 32'h0000_0000, 32'h0000_0000,
                    32'h0002_0000, 8'h20,
                    32'h8001_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
`endif
        // Post-reset ray
        set_vec(13, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
                    32'h0002_0000, 32'h0003_0000, 32'hFFFF_0000,
                    32'h0001_8000, 8'h33,
                    32'h0003_0000, 32'h0004_8000, 32'hFFFE_8000, 1'b0);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_origin = '0; in_dir = '0; in_t = '0; in_id = '0;
        #12;
        chk("rst_out_valid", 96'(out_valid), 96'(1'b0));
        chk("rst_in_ready", 96'(in_ready), 96'(1'b1));
        chk("rst_pos", out_pos, 96'd0);
        chk("rst_t", 96'(out_t), 96'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: single ray, two-cycle latency, no duplicate
        @(negedge clk);
        drive(0); in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("t1_in_ready", 96'(in_ready), 96'(1'b1));
        @(negedge clk);
        in_valid = 1'b0;
        chk("t1_lat1", 96'(out_valid), 96'(1'b0));
        @(negedge clk);
        chk("t1_lat2", 96'(out_valid), 96'(1'b1));
        check_out(0);
        @(negedge clk);
        chk("t1_nodup", 96'(out_valid), 96'(1'b0));

        // Tests 2-5
        run_seq(1, 8, 1'b0);
        run_seq(1, 8, 1'b1);
        run_seq(9, 3, 1'b0);
        run_seq(12, 1, 1'b0);

        // Test 6: reset with both stages full
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; drive(1);
        @(negedge clk);
        drive(2);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("full_in_ready", 96'(in_ready), 96'(1'b0));
        chk("full_out_valid", 96'(out_valid), 96'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 96'(out_valid), 96'(1'b0));
        chk("arst_pos", out_pos, 96'd0);
        chk("arst_id", 96'(out_id), 96'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        chk("rel_in_ready", 96'(in_ready), 96'(1'b1));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("no_stale", 96'(out_valid), 96'(1'b0));
        end
        run_seq(13, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
